// File: rtl/audio_buf_pkg.sv
// Shared definitions for the audio loopback delay buffer:
// default widths, controller state encoding and the mute sample value.
package audio_buf_pkg;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 16;

   localparam logic [DEF_DATA_W-1:0] SAMPLE_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      CAP  = 2'd3
   } buf_state_t;

endpackage

// File: rtl/audio_delay_ctrl.sv
// Circular-buffer sequencer in front of a simple dual-port BRAM:
// writes each input sample, reads back the one 'delay' frames older.
module audio_delay_ctrl
   import audio_buf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] delay,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              overrun,
   output logic              ram_cea,
   output logic [ADDR_W-1:0] ram_ada,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_ceb,
   output logic [ADDR_W-1:0] ram_adb,
   output logic              ram_oce,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W-1:0] FILL_MAX = '1;
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   buf_state_t        state_q;
   buf_state_t        state_d;
   logic [DATA_W-1:0] sample_q;
   logic [ADDR_W-1:0] delay_q;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] fill;
   logic              mute_q;

   // State register; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Fixed four-step walk once a sample is accepted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = WR;
         WR:      state_d = RD;
         RD:      state_d = CAP;
         CAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // BRAM ports are live only in their own state, zero otherwise.
   always_comb begin
      ram_cea = 1'b0;
      ram_ada = '0;
      ram_din = '0;
      ram_ceb = 1'b0;
      ram_adb = '0;
      unique case (state_q)
         WR: begin
            ram_cea = 1'b1;
            ram_ada = wr_ptr;
            ram_din = sample_q;
         end
         RD: begin
            ram_ceb = 1'b1;
            ram_adb = rd_ptr;
         end
         default: begin
            ram_cea = 1'b0;
         end
      endcase
   end

   assign ram_oce = 1'b1;

   // Pointers, fill level, mute decision and output capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q  <= '0;
         delay_q   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         mute_q    <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         overrun   <= in_valid && (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sample_q <= in_data;
                  if (delay != delay_q) begin
                     delay_q <= delay;
                     fill    <= '0;
                  end
               end
            end
            WR: begin
               rd_ptr <= wr_ptr - delay_q;
               mute_q <= fill < delay_q;
            end
            RD: begin
               wr_ptr <= wr_ptr + ONE;
               if (fill != FILL_MAX) begin
                  fill <= fill + ONE;
               end
            end
            CAP: begin
               out_data  <= mute_q ? DATA_W'(SAMPLE_ZERO) : ram_dout;
               out_valid <= 1'b1;
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_delay_ctrl.sv
// Directed bench for audio_delay_ctrl with a behavioural BRAM model:
// vector table plus overrun, reset-abort and pointer-wrap sequences.
module tb_audio_delay_ctrl;

   localparam int AW = 14;
   localparam int DW = 16;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [AW-1:0] delay;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          overrun;
   logic          ram_cea;
   logic [AW-1:0] ram_ada;
   logic [DW-1:0] ram_din;
   logic          ram_ceb;
   logic [AW-1:0] ram_adb;
   logic          ram_oce;
   logic [DW-1:0] ram_dout;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_chk;
   int n_fail;

   typedef struct {
      logic [DW-1:0] data;
      logic [AW-1:0] dly;
      logic [DW-1:0] exp_out;
      logic [AW-1:0] exp_wa;
   } vec_t;

   vec_t vt [16];

   audio_delay_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .delay     (delay),
      .out_valid (out_valid),
      .out_data  (out_data),
      .overrun   (overrun),
      .ram_cea   (ram_cea),
      .ram_ada   (ram_ada),
      .ram_din   (ram_din),
      .ram_ceb   (ram_ceb),
      .ram_adb   (ram_adb),
      .ram_oce   (ram_oce),
      .ram_dout  (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM: write port A, read port B with one-cycle latency
   always @(posedge clk) begin
      if (ram_cea) mem[ram_ada] <= ram_din;
      if (ram_ceb) ram_dout <= mem[ram_adb];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where out_valid shows.
   task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] dl,
                       input logic [DW-1:0] eo, input logic [AW-1:0] ewa,
                       input bit do_chk);
      logic [AW-1:0] era;
      era = ewa - dl;
      in_valid = 1'b1;
      in_data  = d;
      delay    = dl;
      @(negedge clk);
      in_valid = 1'b0;
      if (do_chk) begin
         chk("wr_cea", 32'(ram_cea), 32'd1);
         chk("wr_ada", 32'(ram_ada), 32'(ewa));
         chk("wr_din", 32'(ram_din), 32'(d));
         chk("wr_ceb", 32'(ram_ceb), 32'd0);
      end
      @(negedge clk);
      if (do_chk) begin
         chk("rd_ceb", 32'(ram_ceb), 32'd1);
         chk("rd_adb", 32'(ram_adb), 32'(era));
         chk("rd_cea", 32'(ram_cea), 32'd0);
      end
      @(negedge clk);
      if (do_chk) chk("cap_ovalid", 32'(out_valid), 32'd0);
      @(negedge clk);
      if (do_chk) begin
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("out_data", 32'(out_data), 32'(eo));
      end
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      delay    = '0;

      // delay 0
      vt[0]  = '{16'h1234, 14'd0, 16'h1234, 14'd0};
      vt[1]  = '{16'hABCD, 14'd0, 16'hABCD, 14'd1};
      // delay 3, samples 1..6
      vt[2]  = '{16'd1, 14'd3, 16'd0, 14'd2};
      vt[3]  = '{16'd2, 14'd3, 16'd0, 14'd3};
      vt[4]  = '{16'd3, 14'd3, 16'd0, 14'd4};
      vt[5]  = '{16'd4, 14'd3, 16'd1, 14'd5};
      vt[6]  = '{16'd5, 14'd3, 16'd2, 14'd6};
      vt[7]  = '{16'd6, 14'd3, 16'd3, 14'd7};
      // prime at delay 2
      vt[8]  = '{16'h0010, 14'd2, 16'h0000, 14'd8};
      vt[9]  = '{16'h0011, 14'd2, 16'h0000, 14'd9};
      vt[10] = '{16'h0012, 14'd2, 16'h0010, 14'd10};
      // switch to delay 4
      vt[11] = '{16'h0020, 14'd4, 16'h0000, 14'd11};
      vt[12] = '{16'h0021, 14'd4, 16'h0000, 14'd12};
      vt[13] = '{16'h0022, 14'd4, 16'h0000, 14'd13};
      vt[14] = '{16'h0023, 14'd4, 16'h0000, 14'd14};
      vt[15] = '{16'h0024, 14'd4, 16'h0020, 14'd15};

      repeat (3) @(negedge clk);
      chk("rst_ovalid", 32'(out_valid), 32'd0);
      chk("rst_odata", 32'(out_data), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_cea", 32'(ram_cea), 32'd0);
      chk("rst_ceb", 32'(ram_ceb), 32'd0);
      chk("rst_ada", 32'(ram_ada), 32'd0);
      chk("rst_adb", 32'(ram_adb), 32'd0);
      chk("rst_din", 32'(ram_din), 32'd0);
      chk("rst_oce", 32'(ram_oce), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         push(vt[i].data, vt[i].dly, vt[i].exp_out, vt[i].exp_wa, 1'b1);
      end

      // overrun: second in_valid lands in RD and is dropped
      in_valid = 1'b1;
      in_data  = 16'h0055;
      delay    = 14'd4;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ovr_ada", 32'(ram_ada), 32'd16);
      chk("ovr_pulse_wr", 32'(overrun), 32'd0);
      @(negedge clk);
      chk("ovr_pulse_rd", 32'(overrun), 32'd0);
      in_valid = 1'b1;
      in_data  = 16'h0066;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("ovr_cap_cea", 32'(ram_cea), 32'd0);
      @(negedge clk);
      chk("ovr_pulse_end", 32'(overrun), 32'd0);
      chk("ovr_ovalid", 32'(out_valid), 32'd1);
      chk("ovr_odata", 32'(out_data), 32'h0021);
      push(16'h0077, 14'd4, 16'h0022, 14'd17, 1'b1);

      // reset asserted during RD
      in_valid = 1'b1;
      in_data  = 16'h0088;
      delay    = 14'd4;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("rr_in_rd", 32'(ram_ceb), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rr_ovalid", 32'(out_valid), 32'd0);
      chk("rr_odata", 32'(out_data), 32'd0);
      chk("rr_overrun", 32'(overrun), 32'd0);
      chk("rr_cea", 32'(ram_cea), 32'd0);
      chk("rr_ceb", 32'(ram_ceb), 32'd0);
      chk("rr_ada", 32'(ram_ada), 32'd0);
      chk("rr_adb", 32'(ram_adb), 32'd0);
      chk("rr_din", 32'(ram_din), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rr_no_ov1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("rr_no_ov2", 32'(out_valid), 32'd0);
      push(16'h0099, 14'd1, 16'h0000, 14'd0, 1'b1);

      // advance wr_ptr from 1 to 16382
      for (int i = 0; i < 16381; i++) begin
         push(DW'(i), 14'd5, 16'h0000, 14'd0, 1'b0);
      end

      // wrap-around at delay 2
      push(16'hA0A0, 14'd2, 16'h0000, 14'd16382, 1'b1);
      push(16'hB0B1, 14'd2, 16'h0000, 14'd16383, 1'b1);
      push(16'hC0C2, 14'd2, 16'hA0A0, 14'd0, 1'b1);
      push(16'hD0D3, 14'd2, 16'hB0B1, 14'd1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_delay_ctrl.md
# audio_delay_ctrl

Sequencing controller that sits upstream of the 16-bit x 16K simple dual-port BRAM in the audio loopback path. It takes one PCM sample per frame from the I2S receiver and writes it into the BRAM as a circular buffer. It then reads back the sample written `delay` frames earlier and hands that sample to the I2S transmitter. The controller owns both BRAM ports and the write/read pointers, and mutes its output until the buffer is primed.

## Interface
Parameters:
- `ADDR_W`, 14 — BRAM address width; the buffer depth is 2^ADDR_W samples.
- `DATA_W`, 16 — sample width.

Ports:
- `clk`  in  1  single clock for the whole block. It also drives BRAM `clka` and `clkb`.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle pulse marking that a new sample is present.
- `in_data`  in  DATA_W  signed PCM sample; sampled when `in_valid` is high.
- `delay`  in  ADDR_W  requested delay in frames, 0..2^ADDR_W-1; sampled when `in_valid` is high.
- `out_valid`  out  1  one-cycle pulse marking that `out_data` is updated.
- `out_data`  out  DATA_W  delayed sample; holds its value between pulses.
- `overrun`  out  1  one-cycle pulse when an `in_valid` arrives while the controller is busy.
- `ram_cea`, `ram_ada[ADDR_W-1:0]`, `ram_din[DATA_W-1:0]`  out  — BRAM write port.
- `ram_ceb`, `ram_adb[ADDR_W-1:0]`, `ram_oce`  out  — BRAM read port. `ram_oce` is tied to 1.
- `ram_dout`  in  DATA_W  BRAM read data. It is valid the cycle after `ram_ceb` (bypass read mode, one-cycle latency).

## Operation
- FSM states: IDLE → WR → RD → CAP → IDLE. Each non-IDLE state lasts exactly one cycle.
- **IDLE:** on `in_valid`:
  - Latch `in_data` into `sample_q`.
  - If `delay` ≠ `delay_q`: load `delay_q` ← `delay` and clear `fill` to 0.
  - Go to WR.
- **WR:**
  - Drive `ram_cea`=1, `ram_ada`=`wr_ptr`, `ram_din`=`sample_q`.
  - Compute `rd_ptr` = (`wr_ptr` − `delay_q`) mod 2^ADDR_W.
  - Set `mute_q` = (`fill` < `delay_q`).
- **RD:**
  - Drive `ram_ceb`=1, `ram_adb`=`rd_ptr`.
  - `wr_ptr` increments, wrapping 2^ADDR_W−1 → 0.
  - `fill` increments, saturating at 2^ADDR_W−1.
- **CAP:**
  - Register `out_data` ← `mute_q` ? 0 : `ram_dout`.
  - Register `out_valid` ← 1 for one cycle.
- `fill` counts only the writes completed *before* the current one. The output is therefore unmuted once at least `delay_q` earlier samples exist.
- Delay 0: the read targets the address written in the previous cycle. Because write and read fall in different cycles, the output equals the input sample.
- `in_valid` in any state other than IDLE:
  - The sample is dropped and `overrun` pulses in that same cycle (registered, visible the next cycle).
  - Pointers are not disturbed.
- BRAM enables are asserted only in their own state; `ram_cea` and `ram_ceb` are never high in the same cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `overrun`=0, `ram_cea`=0, `ram_ceb`=0, addresses=0, `ram_din`=0, `wr_ptr`=0, `fill`=0, `delay_q`=0, state IDLE.
- Reset mid-operation:
  - Abort the current sequence immediately; no `out_valid` is emitted for the aborted sample.
  - Buffer contents are irrelevant afterwards because `fill`=0 forces mute.
- Latency: `in_valid` at cycle n → WR at n+1 → RD at n+2 → CAP at n+3 → `out_valid` high at n+4.
- Throughput: one sample every 4 cycles maximum. `in_valid` is legal again in the cycle `out_valid` is high.
- The BRAM output-mux select register depends on `ram_ceb`; `ram_adb` must be held stable in the RD cycle.

## Structure
- Shared package `audio_buf_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults;
  - the FSM state enum `buf_state_t` (IDLE, WR, RD, CAP);
  - a `SAMPLE_ZERO` constant.
- No sub-module is needed. The block is a single FSM plus pointer/fill counters; the BRAM is instantiated by the parent and connected to the `ram_*` ports.

## Test plan
- Delay 0: push 0x1234, then 0xABCD → `out_data` = 0x1234, then 0xABCD, each with `out_valid` at n+4.
- Delay 3: push samples 1..6 → outputs are 0, 0, 0, 1, 2, 3.
- Wrap-around: delay 2, preload so `wr_ptr` = 16382, push A, B, C, D:
  - writes go to 16382, 16383, 0, 1;
  - outputs are 0, 0, A, B;
  - `ram_adb` for C is 16382.
- Delay change: after priming at delay 2, switch `delay` to 4 → next 4 outputs are 0, then the sample from 4 frames back.
- Overrun: assert `in_valid` at n and n+2 → one `overrun` pulse; only the first sample is written; `wr_ptr` advances by 1.
- Reset mid-operation: assert `reset` during RD → no `out_valid`; all outputs return to 0; the next sample with delay 1 outputs 0 (muted).
